// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data memory unit.
package dmem_pkg;
    localparam int WORD_W  = 32;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;
    typedef enum logic [1:0] {IDLE, BUSY, ACK, TURN} state_t;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: LSQ-to-data-memory request/ack bus.
// Ports: mem_req/mem_we/mem_addr/mem_data from the LSQ (master);
// mem_ack/mem_read_val/mem_err/mem_busy from the memory (slave).
interface dmem_if import dmem_pkg::*; ;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [WORD_W-1:0] mem_data;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_read_val;
    logic              mem_err;
    logic              mem_busy;
    modport master (output mem_req, mem_we, mem_addr, mem_data,
                    input  mem_ack, mem_read_val, mem_err, mem_busy);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_data,
                    output mem_ack, mem_read_val, mem_err, mem_busy);
endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word RAM with synchronous read.
// Ports: clk; we/addr/wdata write port; rdata registered read of addr.
module dmem_ram import dmem_pkg::*; #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [WORD_W-1:0]              wdata,
    output logic [WORD_W-1:0]              rdata
);
    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: fixed-latency load/store back end for the LSQ.
// Ports: clk; rst_n async active-low; bus (dmem_if.slave) carrying the
// level-held request, one-cycle ack, read data, misalign error and busy.
module data_memory_unit import dmem_pkg::*; #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);
    localparam int AW  = $clog2(DEPTH_WORDS);
    localparam int LAT = (LATENCY < LAT_MIN) ? LAT_MIN : (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LAT > 1) ? LAT - 2 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rval_q, rval_d;
    logic [WORD_W-1:0] ram_rdata;
    logic [WORD_W-1:0] read_val;
    logic [AW-1:0]     ram_addr;
    logic              ram_we;

    // In IDLE the RAM reads the live port address so a LATENCY of 1 still
    // has its data registered on the edge that enters ACK.
    assign ram_addr = (state_q == IDLE) ? bus.mem_addr[AW+1:2] : idx_q;
    assign ram_we   = (state_q == ACK) && we_q && !err_q;
    // Visible during the ACK of a load, then held in rval_q until the next ack.
    assign read_val = (state_q == ACK && !we_q) ? (err_q ? '0 : ram_rdata) : rval_q;

    assign bus.mem_ack      = (state_q == ACK);
    assign bus.mem_err      = (state_q == ACK) && err_q;
    assign bus.mem_busy     = (state_q != IDLE);
    assign bus.mem_read_val = read_val;

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rval_d  = read_val;
        case (state_q)
            IDLE: if (bus.mem_req) begin
                state_d = (LAT > 1) ? BUSY : ACK;
                cnt_d   = CNT_INIT;
                we_d    = bus.mem_we;
                err_d   = |bus.mem_addr[1:0];
                idx_d   = bus.mem_addr[AW+1:2];
                wdata_d = bus.mem_data;
            end
            BUSY: if (cnt_q == '0) state_d = ACK; else cnt_d = cnt_q - 1'b1;
            ACK:  state_d = TURN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rval_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rval_q  <= rval_d;
        end
    end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: directed self-checking bench for data_memory_unit.
module tb_data_memory_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;

    dmem_if bus ();

    data_memory_unit #(.DEPTH_WORDS(1024), .LATENCY(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Called at a negedge with the DUT idle; returns the ack cycle count
    // (-1 on timeout), read data and error seen with ack, and ack one cycle
    // later. Returns at a negedge with the DUT idle again.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          output int n, output logic [31:0] rv, output logic err, output logic ack2);
        bus.mem_req  = 1'b1;
        bus.mem_we   = we;
        bus.mem_addr = addr;
        bus.mem_data = data;
        n = -1; rv = '0; err = 1'b0; ack2 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.mem_ack) begin
                n = c; rv = bus.mem_read_val; err = bus.mem_err;
                break;
            end
        end
        bus.mem_req = 1'b0;
        @(negedge clk);
        ack2 = bus.mem_ack;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int acks = 0;
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (bus.mem_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", bus.mem_ack); end
        checks++; if (bus.mem_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.mem_err); end
        checks++; if (bus.mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.mem_busy); end
        checks++; if (bus.mem_read_val !== 32'h0) begin errors++; $display("FAIL reset_rval got %h want 0", bus.mem_read_val); end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.mem_ack !== 1'b0 || bus.mem_busy !== 1'b0) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL reset_idle activity cycles got %0d want 0", acks); end
    endtask

    task automatic test_store_load();
        int n; logic [31:0] rv; logic err, ack2;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, n, rv, err, ack2);
        checks++; if (n !== 3) begin errors++; $display("FAIL store_latency got %0d want 3", n); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL store_err got %b want 0", err); end
        checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL store_ack_width got %b want 0", ack2); end
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL store_rval_hold got %h want 0", rv); end
        do_req(1'b0, 32'h10, 32'h0, n, rv, err, ack2);
        checks++; if (n !== 3) begin errors++; $display("FAIL load_latency got %0d want 3", n); end
        checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h want deadbeef", rv); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_err got %b want 0", err); end
        checks++; if (bus.mem_read_val !== 32'hDEADBEEF) begin errors++; $display("FAIL load_hold got %h want deadbeef", bus.mem_read_val); end
    endtask

    task automatic test_back_to_back();
        int acks = 0, first = -1, second = -1;
        logic [31:0] rv2 = '0;
        logic idle5 = 1'b1;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h10; bus.mem_data = '0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 5) idle5 = bus.mem_busy;
            if (bus.mem_ack) begin
                acks++;
                if (first < 0) first = c; else begin second = c; rv2 = bus.mem_read_val; end
            end
            if (c == 8) bus.mem_req = 1'b0;
        end
        checks++; if (acks !== 2) begin errors++; $display("FAIL b2b_ack_count got %0d want 2", acks); end
        checks++; if (first !== 3) begin errors++; $display("FAIL b2b_first_ack got %0d want 3", first); end
        checks++; if (second !== 8) begin errors++; $display("FAIL b2b_second_ack got %0d want 8", second); end
        checks++; if (idle5 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap busy got %b want 0", idle5); end
        checks++; if (rv2 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_data got %h want deadbeef", rv2); end
    endtask

    task automatic test_misaligned();
        int n; logic [31:0] rv; logic err, ack2;
        do_req(1'b1, 32'h13, 32'h12345678, n, rv, err, ack2);
        checks++; if (n !== 3) begin errors++; $display("FAIL mis_store_latency got %0d want 3", n); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_store_err got %b want 1", err); end
        checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_store_rval got %h want deadbeef", rv); end
        do_req(1'b0, 32'h11, 32'h0, n, rv, err, ack2);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_load_err got %b want 1", err); end
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL mis_load_data got %h want 0", rv); end
        do_req(1'b0, 32'h10, 32'h0, n, rv, err, ack2);
        checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_no_write got %h want deadbeef", rv); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_clean_err got %b want 0", err); end
    endtask

    task automatic test_wraparound();
        int n; logic [31:0] rv; logic err, ack2;
        do_req(1'b1, 32'h1004, 32'hA5A5A5A5, n, rv, err, ack2);
        do_req(1'b0, 32'h4, 32'h0, n, rv, err, ack2);
        checks++; if (rv !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_data got %h want a5a5a5a5", rv); end
        do_req(1'b0, 32'h10, 32'h0, n, rv, err, ack2);
        checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_other got %h want deadbeef", rv); end
    endtask

    task automatic test_reset_midop();
        int n; logic [31:0] rv; logic err, ack2;
        int acks = 0;
        do_req(1'b1, 32'h20, 32'hCAFEF00D, n, rv, err, ack2);
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h20; bus.mem_data = 32'h1;
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_ack !== 1'b1) begin errors++; $display("FAIL midop_in_ack got %b want 1", bus.mem_ack); end
        rst_n = 1'b0;
        bus.mem_req = 1'b0;
        #1;
        checks++; if (bus.mem_ack !== 1'b0) begin errors++; $display("FAIL midop_abort_ack got %b want 0", bus.mem_ack); end
        checks++; if (bus.mem_busy !== 1'b0) begin errors++; $display("FAIL midop_abort_busy got %b want 0", bus.mem_busy); end
        repeat (2) begin
            @(negedge clk);
            if (bus.mem_ack) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL midop_no_ack got %0d want 0", acks); end
        checks++; if (bus.mem_read_val !== 32'h0) begin errors++; $display("FAIL midop_rval_reset got %h want 0", bus.mem_read_val); end
        rst_n = 1'b1;
        do_req(1'b0, 32'h20, 32'h0, n, rv, err, ack2);
        checks++; if (n !== 3) begin errors++; $display("FAIL midop_first_edge latency got %0d want 3", n); end
        checks++; if (rv !== 32'hCAFEF00D) begin errors++; $display("FAIL midop_no_write got %h want cafef00d", rv); end
    endtask

    initial begin
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_misaligned();
        test_wraparound();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
